pcie_hcmd_cid_ctrl: RTL and testbench

Slot-tag manager and sequencer for the host-command CID table: a 2^P_SLOT_TAG_WIDTH-entry simple-dual-port BRAM with a 1-cycle read.
- Command-fetch side requests a slot: the block allocates a free slot tag and writes the {SQ id, CID} word into the table.
- Completion side presents a slot tag: the block reads the table, returns the stored word, and optionally frees the slot.
- Sits between the NVMe command fetch/completion paths and the CID table instance.

---
 rtl/pcie_hcmd_cid_ctrl.sv | 235 +++++++++++++++++++++++
 tb/tb_pcie_hcmd_cid_ctrl.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pcie_hcmd_cid_ctrl.sv
// ---------------------------------------------------------------------------
// pcie_hcmd_cid_ctrl
//
// Slot-tag manager and sequencer for the host-command CID table. The table is
// an external simple-dual-port BRAM with a 1-cycle registered read, read
// enable tied high.
//
// The command-fetch side asks for a slot. This block grants a free tag and
// writes the {sq_id, cid} word into the table one cycle later. The completion
// side presents a tag. The block reads the stored word back, returns it, and
// can free the slot when the response handshake completes.
//
// Ports
//   clk, rst             clock, synchronous active-high reset
//   alloc_*              allocation request/grant (valid/ready, tag out)
//   cpl_*                lookup request (tag, release flag, valid/ready)
//   rsp_*                lookup response (data, error, valid/ready)
//   tbl_*                connection to the CID table instance
//   outstanding_cnt      number of allocated slots (registered)
//   full, empty          registered flags derived from the slot count
//   stat_alloc_cnt       allocation counter    (HCMD_CID_STATS_EN only)
//   stat_err_cnt         error-response counter (HCMD_CID_STATS_EN only)
//
// Optional feature macro: HCMD_CID_STATS_EN. When this macro is undefined,
// both stat ports are tied to 0.
// ---------------------------------------------------------------------------
module pcie_hcmd_cid_ctrl #(
    parameter int P_SLOT_TAG_WIDTH = 10,
    parameter int P_DATA_WIDTH     = 20
) (
    input  logic                        clk,
    input  logic                        rst,
    // allocation
    input  logic                        alloc_valid,
    input  logic [P_DATA_WIDTH-1:0]     alloc_data,
    output logic                        alloc_ready,
    output logic [P_SLOT_TAG_WIDTH-1:0] alloc_slot_tag,
    // lookup request
    input  logic                        cpl_valid,
    input  logic [P_SLOT_TAG_WIDTH-1:0] cpl_slot_tag,
    input  logic                        cpl_release,
    output logic                        cpl_ready,
    // lookup response
    output logic                        rsp_valid,
    output logic [P_DATA_WIDTH-1:0]     rsp_data,
    output logic                        rsp_err,
    input  logic                        rsp_ready,
    // table interface
    output logic                        tbl_wr_en,
    output logic [P_SLOT_TAG_WIDTH-1:0] tbl_wr_addr,
    output logic [P_DATA_WIDTH-1:0]     tbl_wr_data,
    output logic [P_SLOT_TAG_WIDTH-1:0] tbl_rd_addr,
    input  logic [P_DATA_WIDTH-1:0]     tbl_rd_data,
    // status
    output logic [P_SLOT_TAG_WIDTH:0]   outstanding_cnt,
    output logic                        full,
    output logic                        empty,
    output logic [31:0]                 stat_alloc_cnt,
    output logic [15:0]                 stat_err_cnt
);

    localparam int DEPTH = 1 << P_SLOT_TAG_WIDTH;
    localparam logic [P_SLOT_TAG_WIDTH:0] DEPTH_C = (P_SLOT_TAG_WIDTH + 1)'(DEPTH);

    typedef enum logic {
        L_IDLE = 1'b0,
        L_RSP  = 1'b1
    } lstate_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [DEPTH-1:0]            busy;
    logic [DEPTH-1:0]            busy_nxt;
    logic [P_SLOT_TAG_WIDTH-1:0] alloc_ptr;
    logic [P_SLOT_TAG_WIDTH:0]   cnt;
    logic [P_SLOT_TAG_WIDTH:0]   cnt_nxt;
    logic                        full_q;
    logic                        empty_q;

    lstate_t                     state;
    lstate_t                     state_nxt;
    logic [P_SLOT_TAG_WIDTH-1:0] lk_tag;
    logic                        lk_rel;
    logic                        lk_err;
    logic                        rsp_first;   // first response cycle: table data is live
    logic [P_DATA_WIDTH-1:0]     rsp_hold;    // word held while the consumer stalls

    logic alloc_hs;
    logic cpl_hs;
    logic rsp_hs;
    logic rel_fire;
    logic hazard;
    logic ptr_adv;

    // ------------------------------------------------------------------
    // Allocator
    // ------------------------------------------------------------------
    assign alloc_ready    = ~busy[alloc_ptr] & ~full_q;
    assign alloc_slot_tag = alloc_ptr;
    assign alloc_hs       = alloc_valid & alloc_ready;

    // The pointer walks over busy slots one per cycle. It holds when the
    // table is full, because no free slot exists to find.
    assign ptr_adv = alloc_hs | (busy[alloc_ptr] & ~full_q);

    assign rel_fire = rsp_hs & lk_rel & ~lk_err;

    // A released slot is never alloc_ptr's slot in the same cycle, because
    // alloc_ready requires that slot to be free. The two writes cannot
    // collide.
    always_comb begin
        busy_nxt = busy;
        if (rel_fire) busy_nxt[lk_tag] = 1'b0;
        if (alloc_hs) busy_nxt[alloc_ptr] = 1'b1;
    end

    always_comb begin
        cnt_nxt = cnt;
        case ({alloc_hs, rel_fire})
            2'b10:   cnt_nxt = cnt + 1'b1;
            2'b01:   cnt_nxt = cnt - 1'b1;
            default: cnt_nxt = cnt;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy        <= '0;
            alloc_ptr   <= '0;
            cnt         <= '0;
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
            tbl_wr_en   <= 1'b0;
            tbl_wr_addr <= '0;
            tbl_wr_data <= '0;
        end else begin
            busy      <= busy_nxt;
            cnt       <= cnt_nxt;
            full_q    <= (cnt_nxt == DEPTH_C);
            empty_q   <= (cnt_nxt == '0);
            tbl_wr_en <= alloc_hs;
            if (ptr_adv) alloc_ptr <= alloc_ptr + 1'b1;
            if (alloc_hs) begin
                tbl_wr_addr <= alloc_ptr;
                tbl_wr_data <= alloc_data;
            end
        end
    end

    assign outstanding_cnt = cnt;
    assign full            = full_q;
    assign empty           = empty_q;

    // ------------------------------------------------------------------
    // Lookup FSM
    // ------------------------------------------------------------------
    // The table reads first. A lookup of a slot whose write lands this cycle
    // would return the old word, so the lookup is stalled for that cycle.
    assign hazard = tbl_wr_en & (tbl_wr_addr == cpl_slot_tag);

    always_comb begin
        state_nxt   = state;
        cpl_ready   = 1'b0;
        rsp_valid   = 1'b0;
        tbl_rd_addr = cpl_slot_tag;
        case (state)
            L_IDLE: begin
                cpl_ready = ~hazard;
                if (cpl_valid & ~hazard) state_nxt = L_RSP;
            end
            L_RSP: begin
                tbl_rd_addr = lk_tag;
                rsp_valid   = 1'b1;
                if (rsp_ready) state_nxt = L_IDLE;
            end
            default: state_nxt = L_IDLE;
        endcase
    end

    assign cpl_hs = cpl_valid & cpl_ready;
    assign rsp_hs = rsp_valid & rsp_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= L_IDLE;
            lk_tag    <= '0;
            lk_rel    <= 1'b0;
            lk_err    <= 1'b0;
            rsp_first <= 1'b0;
            rsp_hold  <= '0;
        end else begin
            state     <= state_nxt;
            rsp_first <= cpl_hs;
            if (cpl_hs) begin
                lk_tag <= cpl_slot_tag;
                lk_rel <= cpl_release;
                lk_err <= ~busy[cpl_slot_tag];
            end
            if (rsp_first) rsp_hold <= tbl_rd_data;
        end
    end

    // The word is captured on the first response cycle. A stalled response
    // then stays stable even if the slot is written later. This can happen
    // on an error lookup of a free slot that gets allocated meanwhile.
    assign rsp_data = rsp_first ? tbl_rd_data : rsp_hold;
    assign rsp_err  = rsp_valid & lk_err;

    // ------------------------------------------------------------------
    // Statistics
    // ------------------------------------------------------------------
`ifdef HCMD_CID_STATS_EN
    logic [31:0] stat_alloc_q;
    logic [15:0] stat_err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_alloc_q <= '0;
            stat_err_q   <= '0;
        end else begin
            if (alloc_hs) stat_alloc_q <= stat_alloc_q + 32'd1;
            if (rsp_hs & lk_err & (stat_err_q != 16'hFFFF))
                stat_err_q <= stat_err_q + 16'd1;
        end
    end

    assign stat_alloc_cnt = stat_alloc_q;
    assign stat_err_cnt   = stat_err_q;
`else
    assign stat_alloc_cnt = '0;
    assign stat_err_cnt   = '0;
`endif

endmodule

// File: tb/tb_pcie_hcmd_cid_ctrl.sv
// ---------------------------------------------------------------------------
// Testbench for pcie_hcmd_cid_ctrl with an 8-entry table (P_SLOT_TAG_WIDTH=3).
// A read-first 1-cycle BRAM is modelled here. The reference model tracks
// slots as a set of busy flags, a slot count, a scan pointer and a copy of
// the table contents. It predicts every output each cycle.
// ---------------------------------------------------------------------------
module tb_pcie_hcmd_cid_ctrl;

    localparam int W     = 3;
    localparam int D     = 20;
    localparam int DEPTH = 1 << W;

    logic         clk = 1'b0;
    logic         rst;
    logic         alloc_valid;
    logic [D-1:0] alloc_data;
    logic         alloc_ready;
    logic [W-1:0] alloc_slot_tag;
    logic         cpl_valid;
    logic [W-1:0] cpl_slot_tag;
    logic         cpl_release;
    logic         cpl_ready;
    logic         rsp_valid;
    logic [D-1:0] rsp_data;
    logic         rsp_err;
    logic         rsp_ready;
    logic         tbl_wr_en;
    logic [W-1:0] tbl_wr_addr;
    logic [D-1:0] tbl_wr_data;
    logic [W-1:0] tbl_rd_addr;
    logic [D-1:0] tbl_rd_data;
    logic [W:0]   outstanding_cnt;
    logic         full;
    logic         empty;
    logic [31:0]  stat_alloc_cnt;
    logic [15:0]  stat_err_cnt;

    always #5 clk = ~clk;

    pcie_hcmd_cid_ctrl #(.P_SLOT_TAG_WIDTH(W), .P_DATA_WIDTH(D)) dut (
        .clk(clk), .rst(rst),
        .alloc_valid(alloc_valid), .alloc_data(alloc_data),
        .alloc_ready(alloc_ready), .alloc_slot_tag(alloc_slot_tag),
        .cpl_valid(cpl_valid), .cpl_slot_tag(cpl_slot_tag),
        .cpl_release(cpl_release), .cpl_ready(cpl_ready),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .rsp_ready(rsp_ready),
        .tbl_wr_en(tbl_wr_en), .tbl_wr_addr(tbl_wr_addr),
        .tbl_wr_data(tbl_wr_data), .tbl_rd_addr(tbl_rd_addr),
        .tbl_rd_data(tbl_rd_data),
        .outstanding_cnt(outstanding_cnt), .full(full), .empty(empty),
        .stat_alloc_cnt(stat_alloc_cnt), .stat_err_cnt(stat_err_cnt)
    );

    // CID table: read-first, 1-cycle read latency
    logic [D-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (tbl_wr_en) mem[tbl_wr_addr] <= tbl_wr_data;
        tbl_rd_data <= mem[tbl_rd_addr];
    end

    // ---------------- reference model ----------------
    bit           busy_m [DEPTH];
    int           ptr_m, cnt_m;
    bit           m_rsp, m_rel, m_err, m_data_ok;
    int           m_tag;
    logic [D-1:0] m_data;
    logic [D-1:0] tbl_m  [DEPTH];
    bit           tbl_ok [DEPTH];
    bit           wp;
    int           wp_tag;
    logic [D-1:0] wp_data;
    int unsigned  st_alloc, st_err;

    int vectors = 0;
    int errs    = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic reset_model();
        for (int i = 0; i < DEPTH; i++) busy_m[i] = 1'b0;
        ptr_m = 0; cnt_m = 0;
        m_rsp = 0; m_rel = 0; m_err = 0; m_tag = 0; m_data_ok = 0; m_data = '0;
        wp = 0; wp_tag = 0; wp_data = '0;
        st_alloc = 0; st_err = 0;
    endtask

    // One clock cycle. Inputs are already set at the negedge. The task checks
    // the outputs, steps the model at the posedge, and returns at the next
    // negedge.
    task automatic cycle();
        bit e_ar, e_cr, hs_a, hs_c, hs_r, adv;
        #1;
        e_ar = !busy_m[ptr_m] && (cnt_m != DEPTH);
        e_cr = !m_rsp && !(wp && wp_tag == int'(cpl_slot_tag));
        chk("alloc_ready", alloc_ready, e_ar);
        chk("alloc_slot_tag", alloc_slot_tag, ptr_m);
        chk("cpl_ready", cpl_ready, e_cr);
        chk("rsp_valid", rsp_valid, m_rsp);
        if (m_rsp) begin
            chk("rsp_err", rsp_err, m_err);
            if (m_data_ok) chk("rsp_data", rsp_data, m_data);
        end
        chk("tbl_wr_en", tbl_wr_en, wp);
        if (wp) begin
            chk("tbl_wr_addr", tbl_wr_addr, wp_tag);
            chk("tbl_wr_data", tbl_wr_data, wp_data);
        end
        chk("outstanding_cnt", outstanding_cnt, cnt_m);
        chk("full", full, cnt_m == DEPTH);
        chk("empty", empty, cnt_m == 0);
`ifdef HCMD_CID_STATS_EN
        chk("stat_alloc_cnt", stat_alloc_cnt, st_alloc);
        chk("stat_err_cnt", stat_err_cnt, st_err);
`else
        chk("stat_alloc_cnt", stat_alloc_cnt, 0);
        chk("stat_err_cnt", stat_err_cnt, 0);
`endif
        hs_a = alloc_valid && e_ar;
        hs_c = cpl_valid && e_cr;
        hs_r = m_rsp && rsp_ready;
        adv  = !hs_a && busy_m[ptr_m] && (cnt_m != DEPTH);
        @(posedge clk);
        if (rst) begin
            if (wp) begin tbl_m[wp_tag] = wp_data; tbl_ok[wp_tag] = 1; end
            reset_model();
        end else begin
            if (hs_c) begin
                m_rsp     = 1;
                m_tag     = int'(cpl_slot_tag);
                m_rel     = cpl_release;
                m_err     = !busy_m[m_tag];
                m_data    = tbl_m[m_tag];
                m_data_ok = tbl_ok[m_tag];
            end
            if (wp) begin tbl_m[wp_tag] = wp_data; tbl_ok[wp_tag] = 1; end
            if (hs_r) begin
                m_rsp = 0;
                if (m_rel && !m_err) begin busy_m[m_tag] = 0; cnt_m--; end
                if (m_err && st_err != 16'hFFFF) st_err++;
            end
            wp = hs_a;
            if (hs_a) begin
                wp_tag  = ptr_m;
                wp_data = alloc_data;
                busy_m[ptr_m] = 1;
                cnt_m++;
                st_alloc++;
                ptr_m = (ptr_m + 1) % DEPTH;
            end else if (adv) begin
                ptr_m = (ptr_m + 1) % DEPTH;
            end
        end
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        alloc_valid = 0; alloc_data = '0;
        cpl_valid = 0; cpl_slot_tag = '0; cpl_release = 0;
        rsp_ready = 1;
    endtask

    task automatic do_reset();
        rst = 1; idle_inputs();
        cycle();
        rst = 0;
    endtask

    int waits;

    initial begin
        for (int i = 0; i < DEPTH; i++) tbl_ok[i] = 0;
        idle_inputs();
        rst = 1;
        reset_model();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 0;

        // back-to-back allocations -> tags 0,1,2
        alloc_valid = 1;
        alloc_data = 20'h10005; cycle();
        alloc_data = 20'h20006; cycle();
        alloc_data = 20'h30007; cycle();
        alloc_valid = 0; cycle();
        chk("cnt_after_3", outstanding_cnt, 3);

        // lookup tag 1 with release
        cpl_valid = 1; cpl_slot_tag = 3'd1; cpl_release = 1; rsp_ready = 0;
        cycle();
        cpl_valid = 0;
        chk("rsp_data_tag1", rsp_data, 20'h20006);
        rsp_ready = 1; cycle(); cycle();
        chk("cnt_after_rel", outstanding_cnt, 2);

        // write-pending hazard on tag 3 (free slots: 1 skipped by scan? ptr=3)
        alloc_valid = 1; alloc_data = 20'h4ABCD; cycle();
        alloc_valid = 0; cpl_valid = 1; cpl_slot_tag = 3'd3; cpl_release = 0;
        #1 chk("hazard_stall", cpl_ready, 0);
        cycle();
        cycle();
        cpl_valid = 0; cycle();
        chk("hazard_data", tbl_m[3], 20'h4ABCD);

        // unallocated tag 7 with release -> error, no state change
        cpl_valid = 1; cpl_slot_tag = 3'd7; cpl_release = 1; cycle();
        cpl_valid = 0; cycle(); cycle();
        chk("err_cnt_unchanged", outstanding_cnt, 3);

        // fill, release tag 5, scan
        do_reset();
        alloc_valid = 1;
        for (int i = 0; i < DEPTH; i++) begin alloc_data = D'($urandom); cycle(); end
        alloc_valid = 0; cycle();
        chk("full_set", full, 1);
        cpl_valid = 1; cpl_slot_tag = 3'd5; cpl_release = 1; cycle();
        cpl_valid = 0; cycle();
        alloc_valid = 1; alloc_data = 20'h5A5A5;
        waits = 0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (alloc_ready) break;
            waits++;
            cycle();
        end
        chk("scan_wait", waits, 5);
        chk("scan_tag", alloc_slot_tag, 5);
        cycle();
        alloc_valid = 0;

        // randomized traffic
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            rst          = ($urandom_range(0, 399) == 0);
            alloc_valid  = ($urandom_range(0, 9) < 5);
            alloc_data   = D'($urandom);
            cpl_valid    = ($urandom_range(0, 9) < 6);
            cpl_slot_tag = W'($urandom);
            cpl_release  = ($urandom_range(0, 9) < 7);
            rsp_ready    = ($urandom_range(0, 9) < 7);
            cycle();
        end
        rst = 0;

        // stall the response, then reset mid-hold
        do_reset();
        alloc_valid = 1; alloc_data = 20'h1CAFE; cycle();
        alloc_valid = 0; cycle();
        cpl_valid = 1; cpl_slot_tag = 3'd0; cpl_release = 1; rsp_ready = 0; cycle();
        cpl_valid = 0;
        repeat (4) begin
            cycle();
            chk("hold_rsp_data", rsp_data, 20'h1CAFE);
            chk("hold_cpl_ready", cpl_ready, 0);
        end
        rst = 1; cycle(); rst = 0;
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_cnt", outstanding_cnt, 0);
        cycle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
